// File: rtl/fifo_sync_fwft_level.sv
// fifo_sync_fwft_level: single-clock FIFO with selectable standard / first-word-fall-through
// read mode, exact fill level, run-time almost-full/almost-empty thresholds and sticky
// overflow/underflow flags. Storage is a DEPTH x DATA_WIDTH array with a registered read.
module fifo_sync_fwft_level #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter bit SHOW_AHEAD = 1'b0,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  empty,
    output logic                  full,
    input  logic [LVL_W-1:0]      af_thresh,
    input  logic [LVL_W-1:0]      ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clear
);

    localparam int               ADDR_W     = LVL_W - 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE        = LVL_W'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one lap bit above the address so wr_ptr - rd_ptr is unambiguous.
    logic [LVL_W-1:0] wr_ptr;
    logic [LVL_W-1:0] rd_ptr;
    logic [LVL_W-1:0] mem_count;
    logic             push_ok;
    logic             pop_ok;
    logic             fetch;

    // Status flags come straight from registered state; thresholds are live inputs.
    assign full         = (level == FULL_LEVEL);
    assign empty        = SHOW_AHEAD ? !read_valid : (level == '0);
    assign almost_full  = (level >= af_thresh);
    assign almost_empty = (level <= ae_thresh);
    assign mem_count    = wr_ptr - rd_ptr;

    // Accept/reject decisions and the array read strobe, from this cycle's flags only.
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        push_ok = write && !full;
        pop_ok  = read && !empty;
        fetch   = 1'b0;
        if (SHOW_AHEAD) begin
            // Refill the head register whenever it is free or being consumed this cycle.
            fetch = (mem_count != '0) && (!read_valid || pop_ok);
        end else begin
            fetch = pop_ok;
        end
    end

    // Storage array write port.
    // NOTE: the array is deliberately not reset; the pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= write_data;
        end
    end

    // Pointer and fill-level bookkeeping; the head word of FWFT mode stays in the level.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + ONE;
                2'b01:   level <= level - ONE;
                default: level <= level;
            endcase
        end
    end

    // Registered read port: standard mode pulses read_valid, FWFT holds the head word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            if (fetch) begin
                read_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
            if (SHOW_AHEAD) begin
                read_valid <= fetch || (read_valid && !pop_ok);
            end else begin
                read_valid <= pop_ok;
            end
        end
    end

    // Sticky error flags; a new error wins over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && full) begin
                overflow <= 1'b1;
            end else if (err_clear) begin
                overflow <= 1'b0;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end else if (err_clear) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_fwft_level.sv
// tb_fifo_sync_fwft_level: drives one standard-mode and one FWFT-mode FIFO (DEPTH=8) with
// the same directed stimulus, compares both every cycle against queue-based models, and
// pins the models with hand-computed literal expectations.
module tb_fifo_sync_fwft_level;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int LVL_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             write;
    logic [DW-1:0]    write_data;
    logic             read;
    logic             err_clear;
    logic [LVL_W-1:0] af_thresh;
    logic [LVL_W-1:0] ae_thresh;

    logic [DW-1:0]    s_read_data, f_read_data;
    logic             s_read_valid, f_read_valid;
    logic             s_empty, f_empty, s_full, f_full;
    logic             s_almost_full, f_almost_full, s_almost_empty, f_almost_empty;
    logic [LVL_W-1:0] s_level, f_level;
    logic             s_overflow, f_overflow, s_underflow, f_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_sync_fwft_level #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SHOW_AHEAD(1'b0)) u_std (
        .clk(clk), .reset(reset), .write(write), .write_data(write_data), .read(read),
        .read_data(s_read_data), .read_valid(s_read_valid), .empty(s_empty), .full(s_full),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(s_almost_full),
        .almost_empty(s_almost_empty), .level(s_level), .overflow(s_overflow),
        .underflow(s_underflow), .err_clear(err_clear)
    );

    fifo_sync_fwft_level #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SHOW_AHEAD(1'b1)) u_fw (
        .clk(clk), .reset(reset), .write(write), .write_data(write_data), .read(read),
        .read_data(f_read_data), .read_valid(f_read_valid), .empty(f_empty), .full(f_full),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .level(f_level), .overflow(f_overflow),
        .underflow(f_underflow), .err_clear(err_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural models ----------------
    // Standard mode: a queue; a pop hands the front word out on the following cycle.
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] ms_rd  = '0;
    logic          ms_rv  = 1'b0;
    logic          ms_ovf = 1'b0;
    logic          ms_unf = 1'b0;
    // FWFT mode: a queue plus push cycle per word; the front word is on show once
    // two cycles have passed since it was pushed.
    logic [DW-1:0] q_f[$];
    int            qt_f[$];
    logic          mf_ovf = 1'b0;
    logic          mf_unf = 1'b0;
    int            cyc = 0;

    function automatic logic fw_shown();
        if (q_f.size() == 0) return 1'b0;
        return (qt_f[0] + 2 <= cyc);
    endfunction

    always @(posedge clk) begin
        logic s_full_m, s_empty_m, f_full_m, f_empty_m;
        if (reset) begin
            q_s.delete(); q_f.delete(); qt_f.delete();
            ms_rd = '0; ms_rv = 1'b0; ms_ovf = 1'b0; ms_unf = 1'b0;
            mf_ovf = 1'b0; mf_unf = 1'b0;
        end else begin
            s_full_m  = (q_s.size() == DEPTH);
            s_empty_m = (q_s.size() == 0);
            ms_rv = read && !s_empty_m;
            if (ms_rv) ms_rd = q_s.pop_front();
            if (write && !s_full_m) q_s.push_back(write_data);
            if (write && s_full_m) ms_ovf = 1'b1; else if (err_clear) ms_ovf = 1'b0;
            if (read && s_empty_m) ms_unf = 1'b1; else if (err_clear) ms_unf = 1'b0;

            f_full_m  = (q_f.size() == DEPTH);
            f_empty_m = !fw_shown();
            if (read && !f_empty_m) begin
                void'(q_f.pop_front());
                void'(qt_f.pop_front());
            end
            if (write && !f_full_m) begin
                q_f.push_back(write_data);
                qt_f.push_back(cyc);
            end
            if (write && f_full_m) mf_ovf = 1'b1; else if (err_clear) mf_ovf = 1'b0;
            if (read && f_empty_m) mf_unf = 1'b1; else if (err_clear) mf_unf = 1'b0;
        end
        cyc++;
    end

    // Per-cycle comparison of both DUTs against the models, away from the active edge.
    always @(negedge clk) begin
        int   ls, lf;
        logic shown;
        if (reset) begin
            check("rst_std_level", s_level, 0);
            check("rst_std_empty", s_empty, 1);
            check("rst_std_rv", s_read_valid, 0);
            check("rst_fw_level", f_level, 0);
            check("rst_fw_empty", f_empty, 1);
            check("rst_fw_rv", f_read_valid, 0);
        end else begin
            ls = q_s.size();
            check("std_level", s_level, ls);
            check("std_empty", s_empty, ls == 0);
            check("std_full", s_full, ls == DEPTH);
            check("std_af", s_almost_full, ls >= int'(af_thresh));
            check("std_ae", s_almost_empty, ls <= int'(ae_thresh));
            check("std_rv", s_read_valid, ms_rv);
            check("std_rd", s_read_data, ms_rd);
            check("std_ovf", s_overflow, ms_ovf);
            check("std_unf", s_underflow, ms_unf);

            lf    = q_f.size();
            shown = fw_shown();
            check("fw_level", f_level, lf);
            check("fw_rv", f_read_valid, shown);
            check("fw_empty", f_empty, !shown);
            check("fw_full", f_full, lf == DEPTH);
            check("fw_af", f_almost_full, lf >= int'(af_thresh));
            check("fw_ae", f_almost_empty, lf <= int'(ae_thresh));
            check("fw_ovf", f_overflow, mf_ovf);
            check("fw_unf", f_underflow, mf_unf);
            if (shown) check("fw_rd", f_read_data, q_f[0]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic ec);
        write = w; write_data = d; read = r; err_clear = ec;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_level"}, s_level, 0);
        check({tag, "_s_empty"}, s_empty, 1);
        check({tag, "_s_full"}, s_full, 0);
        check({tag, "_s_rv"}, s_read_valid, 0);
        check({tag, "_s_rd"}, s_read_data, 0);
        check({tag, "_s_ovf"}, s_overflow, 0);
        check({tag, "_s_unf"}, s_underflow, 0);
        check({tag, "_s_af"}, s_almost_full, 0);
        check({tag, "_s_ae"}, s_almost_empty, 1);
        check({tag, "_f_level"}, f_level, 0);
        check({tag, "_f_empty"}, f_empty, 1);
        check({tag, "_f_rv"}, f_read_valid, 0);
        check({tag, "_f_rd"}, f_read_data, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; write = 1'b0; write_data = '0; read = 1'b0; err_clear = 1'b0;
        af_thresh = 4'd6; ae_thresh = 4'd1;

        // Reset state, including almost_full tracking af_thresh == 0.
        @(negedge clk);
        check_reset_outputs("rst");
        #1 af_thresh = 4'd0;
        #1 check("rst_af_zero", s_almost_full, 1);
        af_thresh = 4'd6;
        #1 check("rst_af_six", s_almost_full, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fill with 0x01..0x08.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        check("fill_s_full", s_full, 1);
        check("fill_s_level", s_level, 8);
        check("fill_f_full", f_full, 1);
        check("fill_f_level", f_level, 8);
        check("fill_f_head", f_read_data, 8'h01);

        // Write while full: rejected, overflow sticky until err_clear.
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_s", s_overflow, 1);
        check("ovf_f", f_overflow, 1);
        check("ovf_s_level", s_level, 8);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr_s", s_overflow, 0);
        check("ovf_clr_f", f_overflow, 0);

        // Drain all eight in order, one per cycle.
        for (int i = 0; i < 8; i++) begin
            check("drain_f_head", f_read_data, DW'(i + 1));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_s_rv", s_read_valid, 1);
            check("drain_s_rd", s_read_data, DW'(i + 1));
        end
        check("drain_s_empty", s_empty, 1);
        check("drain_f_empty", f_empty, 1);
        check("drain_s_level", s_level, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("hold_s_rv", s_read_valid, 0);
        check("hold_s_rd", s_read_data, 8'h08);

        // Read while empty; clear coincident with a new error keeps the flag.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_s", s_underflow, 1);
        check("unf_f", f_underflow, 1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("unf_keep_s", s_underflow, 1);
        check("unf_keep_f", f_underflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr_s", s_underflow, 0);
        check("unf_clr_f", f_underflow, 0);

        // Pointer wrap: three laps of push 6 / pop 6.
        for (int lap = 0; lap < 3; lap++) begin
            for (int k = 0; k < 6; k++) step(1'b1, DW'(8'h20 + lap * 16 + k), 1'b0, 1'b0);
            for (int k = 0; k < 6; k++) begin
                step(1'b0, 8'h00, 1'b1, 1'b0);
                check("wrap_s_rd", s_read_data, DW'(8'h20 + lap * 16 + k));
            end
        end
        check("wrap_s_level", s_level, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Level 4, simultaneous push+pop for 20 cycles.
        for (int k = 0; k < 4; k++) step(1'b1, DW'(8'h40 + k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, DW'(8'h50 + k), 1'b1, 1'b0);
            check("pp_s_level", s_level, 4);
            check("pp_f_level", f_level, 4);
            check("pp_s_rd", s_read_data, (k < 4) ? DW'(8'h40 + k) : DW'(8'h50 + k - 4));
        end
        for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Empty with push+pop together: push taken, pop rejected.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("epp_s_unf", s_underflow, 1);
        check("epp_f_unf", f_underflow, 1);
        check("epp_s_level", s_level, 1);
        check("epp_f_level", f_level, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("epp_s_rd", s_read_data, 8'h77);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // FWFT latency: push 0xA5 in cycle 0 is visible in cycle 2; then 5 pops back to back.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("fw_lat_c1_rv", f_read_valid, 0);
        step(1'b1, 8'hA6, 1'b0, 1'b0);
        check("fw_lat_c2_rv", f_read_valid, 1);
        check("fw_lat_c2_rd", f_read_data, 8'hA5);
        for (int k = 2; k < 5; k++) step(1'b1, DW'(8'hA5 + k), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("fw_burst_rv", f_read_valid, 1);
            check("fw_burst_rd", f_read_data, DW'(8'hA5 + k));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("fw_burst_end_rv", f_read_valid, 0);
        check("fw_burst_end_empty", f_empty, 1);

        // Threshold flags while filling 0 -> 8 with af=6, ae=1.
        for (int k = 0; k <= 8; k++) begin
            check("thr_s_ae", s_almost_empty, k <= 1);
            check("thr_s_af", s_almost_full, k >= 6);
            check("thr_f_ae", f_almost_empty, k <= 1);
            check("thr_f_af", f_almost_full, k >= 6);
            if (k < 8) step(1'b1, DW'(8'h60 + k), 1'b0, 1'b0);
        end
        ae_thresh = 4'd8;
        #1 check("thr_live_ae_on", s_almost_empty, 1);
        ae_thresh = 4'd1;
        #1 check("thr_live_ae_off", s_almost_empty, 0);
        for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Async reset mid-burst at level 5.
        for (int k = 0; k < 5; k++) step(1'b1, DW'(8'h80 + k), 1'b0, 1'b0);
        check("mid_s_level", s_level, 5);
        write = 1'b1; write_data = 8'h99;
        #2 reset = 1'b1;
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_s_level", s_level, 0);
        check("post_rst_f_level", f_level, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
